// File: rtl/aquila_config_pkg.sv
// Shared Aquila configuration: SBA bridge state encoding and default device timeout.
package aquila_config_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CORE_XFER = 2'd1,
    DM_XFER   = 2'd2
  } sba_state_e;

  localparam int unsigned SBA_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/dm_sba_arbiter.sv
// Two-way round-robin arbiter between the core port and the debug-module SBA port.
module dm_sba_arbiter (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_core_i,
  input  logic req_dm_i,
  output logic gnt_core_o,
  output logic gnt_dm_o
);

  // Reset to "DM granted last" so the core wins the first tie.
  logic last_dm_q, last_dm_d;

  always_comb begin
    gnt_core_o = 1'b0;
    gnt_dm_o   = 1'b0;
    last_dm_d  = last_dm_q;
    if (en_i) begin
      if (req_core_i && (!req_dm_i || last_dm_q)) begin
        gnt_core_o = 1'b1;
        last_dm_d  = 1'b0;
      end else if (req_dm_i) begin
        gnt_dm_o  = 1'b1;
        last_dm_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_dm_q <= 1'b1;
    else         last_dm_q <= last_dm_d;
  end

endmodule

// File: rtl/dm_sba_bridge.sv
// Shares one device bus between the Aquila core port and the debug-module SBA port,
// one transaction at a time, with a per-transaction ready timeout.
module dm_sba_bridge
  import aquila_config_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = SBA_TIMEOUT_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_strobe_i,
  input  logic [XLEN-1:0]   core_addr_i,
  input  logic              core_we_i,
  input  logic [XLEN/8-1:0] core_be_i,
  input  logic [XLEN-1:0]   core_wdata_i,
  output logic              core_ready_o,
  output logic [XLEN-1:0]   core_rdata_o,
  input  logic              dm_req_i,
  input  logic [XLEN-1:0]   dm_addr_i,
  input  logic              dm_we_i,
  input  logic [XLEN/8-1:0] dm_be_i,
  input  logic [XLEN-1:0]   dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_r_valid_o,
  output logic              dm_r_err_o,
  output logic [XLEN-1:0]   dm_r_rdata_o,
  output logic              dev_strobe_o,
  output logic [XLEN-1:0]   dev_addr_o,
  output logic              dev_we_o,
  output logic [XLEN/8-1:0] dev_be_o,
  output logic [XLEN-1:0]   dev_wdata_o,
  input  logic              dev_ready_i,
  input  logic [XLEN-1:0]   dev_rdata_i
);

  localparam int unsigned BW = XLEN / 8;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            we;
    logic [BW-1:0]   be;
    logic [XLEN-1:0] wdata;
  } bus_req_t;

  sba_state_e      state_q, state_d;
  logic            core_pend_q, core_pend_d;
  bus_req_t        core_req_q, core_req_d;
  bus_req_t        dev_req_q, dev_req_d;
  logic            strobe_q, strobe_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            core_ready_q, core_ready_d;
  logic [XLEN-1:0] core_rdata_q, core_rdata_d;
  logic            dm_valid_q, dm_valid_d;
  logic            dm_err_q, dm_err_d;
  logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
  logic            done;
  logic            arb_en, gnt_core, gnt_dm;
  bus_req_t        core_live, core_sel, dm_live;

  assign core_live = '{addr: core_addr_i, we: core_we_i, be: core_be_i, wdata: core_wdata_i};
  assign dm_live   = '{addr: dm_addr_i, we: dm_we_i, be: dm_be_i, wdata: dm_wdata_i};
  assign core_sel  = core_pend_q ? core_req_q : core_live;

  // Gating with rst_ni keeps the combinational grant low while reset is held.
  assign arb_en = rst_ni && (state_q == IDLE);

  dm_sba_arbiter u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (arb_en),
    .req_core_i (core_pend_q | core_strobe_i),
    .req_dm_i   (dm_req_i),
    .gnt_core_o (gnt_core),
    .gnt_dm_o   (gnt_dm)
  );

  always_comb begin
    state_d      = state_q;
    core_pend_d  = core_pend_q;
    core_req_d   = core_req_q;
    dev_req_d    = dev_req_q;
    strobe_d     = 1'b0;
    cnt_d        = cnt_q;
    core_ready_d = 1'b0;
    core_rdata_d = '0;
    dm_valid_d   = 1'b0;
    dm_err_d     = 1'b0;
    dm_rdata_d   = '0;
    done         = 1'b0;

    // A strobe while one is already pending, or while the core owns the bus, is lost.
    if (core_strobe_i && !core_pend_q && (state_q != CORE_XFER)) begin
      core_pend_d = 1'b1;
      core_req_d  = core_live;
    end

    case (state_q)
      IDLE: begin
        if (gnt_core) begin
          core_pend_d = 1'b0;
          dev_req_d   = core_sel;
          strobe_d    = 1'b1;
          cnt_d       = '0;
          state_d     = CORE_XFER;
        end else if (gnt_dm) begin
          dev_req_d = dm_live;
          strobe_d  = 1'b1;
          cnt_d     = '0;
          state_d   = DM_XFER;
        end
      end
      CORE_XFER, DM_XFER: begin
        // Ready on the expiry cycle still counts as a normal completion.
        done = dev_ready_i || (cnt_q == CW'(TIMEOUT_CYCLES));
        if (done) begin
          state_d = IDLE;
          if (state_q == CORE_XFER) begin
            core_ready_d = 1'b1;
            core_rdata_d = dev_ready_i ? dev_rdata_i : '0;
          end else begin
            dm_valid_d = 1'b1;
            dm_err_d   = !dev_ready_i;
            dm_rdata_d = dev_ready_i ? dev_rdata_i : '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      core_pend_q  <= 1'b0;
      core_req_q   <= '0;
      dev_req_q    <= '0;
      strobe_q     <= 1'b0;
      cnt_q        <= '0;
      core_ready_q <= 1'b0;
      core_rdata_q <= '0;
      dm_valid_q   <= 1'b0;
      dm_err_q     <= 1'b0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      core_pend_q  <= core_pend_d;
      core_req_q   <= core_req_d;
      dev_req_q    <= dev_req_d;
      strobe_q     <= strobe_d;
      cnt_q        <= cnt_d;
      core_ready_q <= core_ready_d;
      core_rdata_q <= core_rdata_d;
      dm_valid_q   <= dm_valid_d;
      dm_err_q     <= dm_err_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign dm_gnt_o     = gnt_dm;
  assign dev_strobe_o = strobe_q;
  assign dev_addr_o   = dev_req_q.addr;
  assign dev_we_o     = dev_req_q.we;
  assign dev_be_o     = dev_req_q.be;
  assign dev_wdata_o  = dev_req_q.wdata;
  assign core_ready_o = core_ready_q;
  assign core_rdata_o = core_rdata_q;
  assign dm_r_valid_o = dm_valid_q;
  assign dm_r_err_o   = dm_err_q;
  assign dm_r_rdata_o = dm_rdata_q;

endmodule

// File: tb/tb_dm_sba_bridge.sv
// Bench for dm_sba_bridge: directed vector table, hand-built corner sequences and
// random transactions checked against a transaction-level timing/arbitration model.
module tb_dm_sba_bridge;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_strobe_i;
  logic [31:0] core_addr_i;
  logic        core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_wdata_i;
  logic        core_ready_o;
  logic [31:0] core_rdata_o;
  logic        dm_req_i;
  logic [31:0] dm_addr_i;
  logic        dm_we_i;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_wdata_i;
  logic        dm_gnt_o;
  logic        dm_r_valid_o;
  logic        dm_r_err_o;
  logic [31:0] dm_r_rdata_o;
  logic        dev_strobe_o;
  logic [31:0] dev_addr_o;
  logic        dev_we_o;
  logic [3:0]  dev_be_o;
  logic [31:0] dev_wdata_o;
  logic        dev_ready_i;
  logic [31:0] dev_rdata_i;

  dm_sba_bridge #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_strobe_i(core_strobe_i), .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_ready_o(core_ready_o), .core_rdata_o(core_rdata_o),
    .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_r_valid_o(dm_r_valid_o),
    .dm_r_err_o(dm_r_err_o), .dm_r_rdata_o(dm_r_rdata_o),
    .dev_strobe_o(dev_strobe_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
    .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_ready_i(dev_ready_i), .dev_rdata_i(dev_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit model_last_dm;   // arbitration history: 1 = DM granted last

  // Core fields injected by serve() at a chosen transfer cycle.
  logic [31:0] inj_addr, inj_wdata;
  logic        inj_we;
  logic [3:0]  inj_be;

  typedef struct {
    int          mode;      // 0 core only, 1 DM only, 2 both in the same cycle
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;       // device ready this many cycles after the strobe cycle
    logic [31:0] rdata;
    bit          first_dm;  // expected winner of the first arbitration
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic scramble_core();
    core_addr_i  = $urandom;
    core_we_i    = 1'($urandom);
    core_be_i    = 4'($urandom);
    core_wdata_i = $urandom;
  endtask

  // Entered in the arbitration cycle with inputs settled; returns in the response cycle.
  task automatic serve(input bit is_dm, input logic [31:0] a, input bit w, input logic [3:0] b,
                       input logic [31:0] wd, input int lat, input logic [31:0] rd,
                       input logic [31:0] exp_rd, input bit exp_err, input int inj_at);
    int resp_off;
    bit early;
    resp_off = (lat <= TO) ? lat : TO;
    chk("gnt", dm_gnt_o, is_dm);
    model_last_dm = is_dm;
    tick();
    core_strobe_i = 1'b0;
    scramble_core();
    if (is_dm) dm_req_i = 1'b0;
    dev_ready_i = (lat == 0);
    dev_rdata_i = (lat == 0) ? rd : $urandom;
    #1;
    chk("dev_strobe", dev_strobe_o, 1);
    chk("dev_addr", dev_addr_o, a);
    chk("dev_we_be", {dev_we_o, dev_be_o}, {w, b});
    chk("dev_wdata", dev_wdata_o, wd);
    early = 1'b0;
    for (int c = 1; c <= resp_off; c++) begin
      tick();
      if (c == inj_at) begin
        core_strobe_i = 1'b1;
        core_addr_i = inj_addr; core_we_i = inj_we; core_be_i = inj_be; core_wdata_i = inj_wdata;
      end else begin
        core_strobe_i = 1'b0;
        scramble_core();
      end
      dev_ready_i = (c == lat);
      dev_rdata_i = (c == lat) ? rd : $urandom;
      #1;
      if (core_ready_o || dm_r_valid_o || dev_strobe_o || dm_gnt_o) early = 1'b1;
    end
    chk("quiet_during_xfer", early, 0);
    tick();
    core_strobe_i = 1'b0;
    dev_ready_i   = 1'b0;
    dev_rdata_i   = $urandom;
    #1;
    chk("core_ready", core_ready_o, !is_dm);
    chk("dm_r_valid", dm_r_valid_o, is_dm);
    chk("dm_r_err", dm_r_err_o, is_dm & exp_err);
    chk("core_rdata", core_rdata_o, is_dm ? 32'h0 : exp_rd);
    chk("dm_r_rdata", dm_r_rdata_o, is_dm ? exp_rd : 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    logic [31:0] ca, da, cw, dw, crd, drd;
    bit cwe, dwe, fdm;
    logic [3:0] cb, db;
    int mode, clat, dlat;

    vecs[0] = '{2, 32'h8000_0010, 1'b0, 4'hF, 32'h0,         1,  32'hAAAA_0001, 1'b0, 32'hAAAA_0001, 1'b0};
    vecs[1] = '{2, 32'h8000_0020, 1'b1, 4'h3, 32'h5555_0000, 3,  32'hBBBB_0002, 1'b0, 32'hBBBB_0002, 1'b0};
    vecs[2] = '{1, 32'hC000_0004, 1'b0, 4'hF, 32'h0,         1,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};
    vecs[3] = '{1, 32'hC000_0008, 1'b0, 4'hF, 32'h0,         TO, 32'h0F0F_0F0F, 1'b1, 32'h0F0F_0F0F, 1'b0};
    vecs[4] = '{1, 32'hC000_000C, 1'b1, 4'hF, 32'hA5A5_A5A5, 40, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1};
    vecs[5] = '{0, 32'h0000_1000, 1'b0, 4'h1, 32'h0,         0,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0};
    vecs[6] = '{0, 32'h0000_2000, 1'b1, 4'hC, 32'h1111_2222, 30, 32'h3333_4444, 1'b0, 32'h0,         1'b0};
    vecs[7] = '{1, 32'hC000_0010, 1'b0, 4'hF, 32'h0,         TO+1, 32'h7777_7777, 1'b1, 32'h0,       1'b1};

    rst_ni = 1'b0;
    core_strobe_i = 1'b0; dm_req_i = 1'b0; dev_ready_i = 1'b0; dev_rdata_i = '0;
    core_addr_i = '0; core_we_i = 1'b0; core_be_i = '0; core_wdata_i = '0;
    dm_addr_i = '0; dm_we_i = 1'b0; dm_be_i = '0; dm_wdata_i = '0;
    model_last_dm = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    chk("reset_outputs", {dev_strobe_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o, core_ready_o,
                          core_rdata_o, dm_gnt_o, dm_r_valid_o, dm_r_err_o, dm_r_rdata_o}, 0);
    tick();
    rst_ni = 1'b1;

    // Directed vectors, starting from the post-reset arbitration history.
    for (int i = 0; i < 8; i++) begin
      tick();
      if (vecs[i].mode != 1) begin
        core_strobe_i = 1'b1;
        core_addr_i = vecs[i].addr; core_we_i = vecs[i].we;
        core_be_i = vecs[i].be; core_wdata_i = vecs[i].wdata;
      end
      if (vecs[i].mode != 0) begin
        dm_req_i = 1'b1;
        dm_addr_i = vecs[i].addr; dm_we_i = vecs[i].we;
        dm_be_i = vecs[i].be; dm_wdata_i = vecs[i].wdata;
      end
      #1;
      serve(vecs[i].first_dm, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata,
            vecs[i].lat, vecs[i].rdata, vecs[i].exp_rd, vecs[i].exp_err, -1);
      if (vecs[i].mode == 2)
        serve(!vecs[i].first_dm, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata,
              vecs[i].lat, vecs[i].rdata, vecs[i].exp_rd, vecs[i].exp_err, -1);
    end

    // DM write that never completes, then a late ready while idle.
    tick();
    dm_req_i = 1'b1; dm_addr_i = 32'hC000_0100; dm_we_i = 1'b1; dm_be_i = 4'hF; dm_wdata_i = 32'hA5A5_A5A5;
    #1;
    serve(1'b1, 32'hC000_0100, 1'b1, 4'hF, 32'hA5A5_A5A5, 100, 32'h0, 32'h0, 1'b1, -1);
    tick();
    dev_ready_i = 1'b1; dev_rdata_i = 32'hDEAD_BEEF;
    #1;
    tick();
    dev_ready_i = 1'b0;
    #1;
    chk("late_ready_ignored", {core_ready_o, dm_r_valid_o, dm_r_err_o, dev_strobe_o}, 0);

    // Core strobe during a DM transfer waits in core_pend and issues at the DM response.
    inj_addr = 32'h0000_3000; inj_we = 1'b1; inj_be = 4'h6; inj_wdata = 32'hCAFE_0001;
    tick();
    dm_req_i = 1'b1; dm_addr_i = 32'hC000_0200; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_wdata_i = 32'h0;
    #1;
    serve(1'b1, 32'hC000_0200, 1'b0, 4'hF, 32'h0, 5, 32'h5A5A_0003, 32'h5A5A_0003, 1'b0, 2);
    serve(1'b0, 32'h0000_3000, 1'b1, 4'h6, 32'hCAFE_0001, 2, 32'h0000_BEEF, 32'h0000_BEEF, 1'b0, -1);

    // Core strobe during a core transfer is dropped: nothing issues after the response.
    inj_addr = 32'h0000_4000;
    tick();
    core_strobe_i = 1'b1; core_addr_i = 32'h0000_5000; core_we_i = 1'b0; core_be_i = 4'hF; core_wdata_i = 32'h0;
    #1;
    serve(1'b0, 32'h0000_5000, 1'b0, 4'hF, 32'h0, 3, 32'h0000_0055, 32'h0000_0055, 1'b0, 1);
    tick();
    #1;
    chk("dropped_strobe", dev_strobe_o, 0);

    // Reset in the middle of a core transfer.
    tick();
    core_strobe_i = 1'b1; core_addr_i = 32'h1000_0040; core_we_i = 1'b1; core_be_i = 4'hF; core_wdata_i = 32'h9999_0000;
    #1;
    chk("rst_seq_gnt", dm_gnt_o, 0);
    tick();
    core_strobe_i = 1'b0;
    #1;
    chk("rst_seq_strobe", dev_strobe_o, 1);
    tick();
    rst_ni = 1'b0;
    #1;
    chk("reset_mid_xfer", {dev_strobe_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o, core_ready_o,
                           core_rdata_o, dm_gnt_o, dm_r_valid_o, dm_r_err_o, dm_r_rdata_o}, 0);
    tick();
    dev_ready_i = 1'b1; dev_rdata_i = 32'h1357_9BDF;
    #1;
    tick();
    rst_ni = 1'b1;
    #1;
    tick();
    dev_ready_i = 1'b0;
    #1;
    chk("no_resp_after_reset", {core_ready_o, core_rdata_o, dm_r_valid_o, dev_strobe_o}, 0);
    model_last_dm = 1'b1;
    tick();
    dm_req_i = 1'b1; dm_addr_i = 32'hC000_0300; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_wdata_i = 32'h0;
    #1;
    serve(1'b1, 32'hC000_0300, 1'b0, 4'hF, 32'h0, 2, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0, -1);

    // Random transactions against the round-robin / latency model.
    for (int it = 0; it < 60; it++) begin
      mode = int'($urandom_range(0, 2));
      ca = $urandom; cwe = 1'($urandom); cb = 4'($urandom); cw = $urandom; crd = $urandom;
      da = $urandom; dwe = 1'($urandom); db = 4'($urandom); dw = $urandom; drd = $urandom;
      clat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO + 1, TO + 6)) : int'($urandom_range(0, TO));
      dlat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO + 1, TO + 6)) : int'($urandom_range(0, TO));
      repeat (int'($urandom_range(1, 3))) tick();
      if (mode != 1) begin
        core_strobe_i = 1'b1; core_addr_i = ca; core_we_i = cwe; core_be_i = cb; core_wdata_i = cw;
      end
      if (mode != 0) begin
        dm_req_i = 1'b1; dm_addr_i = da; dm_we_i = dwe; dm_be_i = db; dm_wdata_i = dw;
      end
      #1;
      fdm = (mode == 1) || (mode == 2 && !model_last_dm);
      for (int k = 0; k < ((mode == 2) ? 2 : 1); k++) begin
        if (fdm)
          serve(1'b1, da, dwe, db, dw, dlat, drd, (dlat <= TO) ? drd : 32'h0, dlat > TO, -1);
        else
          serve(1'b0, ca, cwe, cb, cw, clat, crd, (clat <= TO) ? crd : 32'h0, 1'b0, -1);
        fdm = !fdm;
      end
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_sba_bridge.md
DM_SBA_BRIDGE -- requirements
Module: dm_sba_bridge

Interface
REQ-001 SHALL have parameter XLEN, default 32, bus data and address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles to wait for dev_ready_i.
REQ-003 SHALL have clk_i, input, 1: single clock for all logic.
REQ-004 SHALL have rst_ni, input, 1: asynchronous active-low reset.
REQ-005 SHALL have core_strobe_i, input, 1: one-cycle request pulse from the Aquila device port.
REQ-006 SHALL have core_addr_i, input, XLEN: core request address.
REQ-007 SHALL have core_we_i, input, 1: core write enable.
REQ-008 SHALL have core_be_i, input, XLEN/8: core byte enables.
REQ-009 SHALL have core_wdata_i, input, XLEN: core write data.
REQ-010 SHALL have core_ready_o, output, 1: one-cycle completion pulse to the core.
REQ-011 SHALL have core_rdata_o, output, XLEN: core read data, valid with core_ready_o.
REQ-012 SHALL have dm_req_i, input, 1: debug-module SBA request, held until granted.
REQ-013 SHALL have dm_addr_i, dm_we_i, dm_be_i and dm_wdata_i as inputs of width XLEN, 1, XLEN/8 and XLEN: debug-module request fields.
REQ-014 SHALL have dm_gnt_o, output, 1: request accepted.
REQ-015 SHALL have dm_r_valid_o, output, 1: one-cycle response pulse to the debug module.
REQ-016 SHALL have dm_r_err_o, output, 1: response error flag, valid with dm_r_valid_o.
REQ-017 SHALL have dm_r_rdata_o, output, XLEN: response read data.
REQ-018 SHALL have dev_strobe_o, dev_addr_o, dev_we_o, dev_be_o and dev_wdata_o as outputs of width 1, XLEN, 1, XLEN/8 and XLEN: shared device bus request.
REQ-019 SHALL have dev_ready_i, input, 1, and dev_rdata_i, input, XLEN: device completion and read data.

Function
REQ-020 SHALL implement FSM states IDLE, CORE_XFER and DM_XFER, with one transaction outstanding at a time.
REQ-021 SHALL capture a core_strobe_i pulse into a core_pend register in any state; core_pend SHALL clear when that request issues.
REQ-022 In IDLE, a core request is core_pend or core_strobe_i. If only one source requests, it SHALL win. If both request, the source not granted last SHALL win (round-robin via a last_grant flag).
REQ-023 On a DM win, dm_gnt_o SHALL be asserted combinationally in that IDLE cycle for exactly one cycle, and the request fields SHALL be latched.
REQ-024 dev_strobe_o SHALL pulse for one cycle, the cycle after the win. dev_addr_o, dev_we_o, dev_be_o and dev_wdata_o SHALL be registered and stable until completion.
REQ-025 When dev_ready_i is seen in an XFER state at cycle M, the bridge SHALL pulse core_ready_o or dm_r_valid_o (matching the owner) at M+1 with the registered dev_rdata_i, then return to IDLE. This applies to writes too.
REQ-026 Latency: request at cycle N with device ready at N+1 gives a response at N+2. The next arbitration SHALL happen in the response cycle.
REQ-027 A cycle counter SHALL start at dev_strobe_o. If it reaches TIMEOUT_CYCLES without dev_ready_i, the bridge SHALL respond with rdata 0, set dm_r_err_o=1 for DM or give a plain core_ready_o for core, and return to IDLE.
REQ-028 If dev_ready_i coincides with timeout expiry, ready SHALL win and no error SHALL be flagged.
REQ-029 dev_ready_i arriving in IDLE (late after a timeout) SHALL be ignored.
REQ-030 dm_req_i dropped before grant SHALL be treated as withdrawn, with no grant issued.
REQ-031 dm_r_err_o SHALL be 0 except on a DM timeout response. Response outputs SHALL be 0 outside their valid pulses.
REQ-032 A core_strobe_i arriving while core_pend is set or in CORE_XFER SHALL be dropped; this is a protocol violation.

Reset
REQ-033 Assertion of rst_ni SHALL immediately clear state to IDLE and clear core_pend, last_grant (set to DM, so the core wins the first tie), the counter, all strobe, ready, valid and err outputs, and all data and address outputs to 0.
REQ-034 Reset mid-transaction SHALL drop the transaction with no response; a device ready after reset SHALL be ignored.

Structure
REQ-035 The FSM state encoding and the default TIMEOUT_CYCLES SHALL live in the shared aquila_config package/header.
REQ-036 The block SHALL be a single module. An optional sub-module dm_sba_arbiter (two-way round-robin) is permitted.

Verification
REQ-037 DM read 0xC000_0004, device ready 1 cycle later with 0x1234_5678 -> gnt at N, strobe at N+1, dm_r_valid_o at N+3 with 0x1234_5678 and err=0.
REQ-038 Core strobe and dm_req_i in the same IDLE cycle after reset -> core issues first; DM granted in the core response cycle; then a third tie -> core granted.
REQ-039 DM write 0xA5A5_A5A5, be=4'hF, device never ready, TIMEOUT_CYCLES=16 -> dm_r_valid_o with err=1 and rdata 0 at strobe+17; a late ready is ignored.
REQ-040 Core strobe during DM_XFER -> held in core_pend, issued the cycle after the DM response, core_ready_o returned correctly.
REQ-041 rst_ni low during CORE_XFER -> all outputs 0 immediately, no core_ready_o, next DM request serviced normally.
